// File: rtl/button_conditioner.sv
// Button front end for the Connect Four controls: synchronises, debounces and
// edge-detects three raw push-buttons. It produces one-cycle move/drop strobes.
// Left and right auto-repeat while they are held.
//
// Ports:
//   clk_25MHz   in   system clock, sole domain
//   rst         in   synchronous reset, active-high
//   btn_right   in   raw button, asynchronous, active-high
//   btn_left    in   raw button, asynchronous, active-high
//   btn_drop    in   raw button, asynchronous, active-high
//   move_right  out  one-cycle strobe, registered
//   move_left   out  one-cycle strobe, registered
//   drop_piece  out  one-cycle strobe, registered
//   btn_held    out  debounced levels {drop,left,right}, registered
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_PERIOD   = 3750000
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_drop,
    output logic       move_right,
    output logic       move_left,
    output logic       drop_piece,
    output logic [2:0] btn_held
);

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned NUM_RPT = 2;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // bit order everywhere: [0]=right, [1]=left, [2]=drop
    logic [NUM_BTN-1:0] raw_c;
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] deb_q, deb_d;
    logic [NUM_BTN-1:0] held_q, held_d;
    logic [NUM_BTN-1:0] held_prev_q, held_prev_d;
    logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
    logic [DB_W-1:0]    db_cnt_d [NUM_BTN];

    rpt_state_e         rpt_st_q  [NUM_RPT];
    rpt_state_e         rpt_st_d  [NUM_RPT];
    logic [RPT_W-1:0]   rpt_cnt_q [NUM_RPT];
    logic [RPT_W-1:0]   rpt_cnt_d [NUM_RPT];

    logic [NUM_BTN-1:0] rise_c;
    logic [NUM_RPT-1:0] move_cand_c;
    logic               drop_cand_c;
    logic               both_moves_c;

    logic               move_right_q, move_right_d;
    logic               move_left_q,  move_left_d;
    logic               drop_piece_q, drop_piece_d;

    assign raw_c = {btn_drop, btn_left, btn_right};

    // Next-state logic: synchroniser, debounce, repeat FSMs and arbitration.
    always_comb begin
        sync1_d      = raw_c;
        sync2_d      = sync1_q;
        deb_d        = deb_q;
        held_d       = deb_q;
        held_prev_d  = held_q;
        move_cand_c  = '0;
        rise_c       = held_q & ~held_prev_q;
        drop_cand_c  = rise_c[2];
        both_moves_c = held_q[0] & held_q[1];

        // Counter only advances while the synced level disagrees with the accepted one.
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end

        // Repeat timers count down and fire on the cycle the count is 1,
        // so a load of N yields strobes spaced exactly N cycles apart.
        for (int i = 0; i < int'(NUM_RPT); i++) begin
            rpt_st_d[i]  = rpt_st_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (!held_q[i]) begin
                rpt_st_d[i]  = RPT_IDLE;
                rpt_cnt_d[i] = '0;
            end else begin
                case (rpt_st_q[i])
                    RPT_IDLE: begin
                        if (rise_c[i]) begin
                            move_cand_c[i] = 1'b1;
                            rpt_cnt_d[i]   = RPT_W'(REPEAT_DELAY);
                            rpt_st_d[i]    = RPT_DELAY;
                        end
                    end
                    RPT_DELAY, RPT_REPEAT: begin
                        if (rpt_cnt_q[i] <= RPT_W'(1)) begin
                            move_cand_c[i] = 1'b1;
                            rpt_cnt_d[i]   = RPT_W'(REPEAT_PERIOD);
                            rpt_st_d[i]    = RPT_REPEAT;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] - RPT_W'(1);
                        end
                    end
                    default: begin
                        rpt_st_d[i]  = RPT_IDLE;
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end

        // Drop beats any coincident move; both moves held masks both outright.
        drop_piece_d = drop_cand_c;
        move_right_d = move_cand_c[0] & ~both_moves_c & ~drop_cand_c;
        move_left_d  = move_cand_c[1] & ~both_moves_c & ~drop_cand_c;
    end

    // State registers.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            held_q       <= '0;
            held_prev_q  <= '0;
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            drop_piece_q <= 1'b0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < int'(NUM_RPT); i++) begin
                rpt_st_q[i]  <= RPT_IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            held_q       <= held_d;
            held_prev_q  <= held_prev_d;
            move_right_q <= move_right_d;
            move_left_q  <= move_left_d;
            drop_piece_q <= drop_piece_d;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < int'(NUM_RPT); i++) begin
                rpt_st_q[i]  <= rpt_st_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign move_right = move_right_q;
    assign move_left  = move_left_q;
    assign drop_piece = drop_piece_q;
    assign btn_held   = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    logic       clk_25MHz;
    logic       rst;
    logic       btn_right;
    logic       btn_left;
    logic       btn_drop;
    logic       move_right;
    logic       move_left;
    logic       drop_piece;
    logic [2:0] btn_held;

    int tests_run;
    int tests_failed;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .btn_right (btn_right),
        .btn_left  (btn_left),
        .btn_drop  (btn_drop),
        .move_right(move_right),
        .move_left (move_left),
        .drop_piece(drop_piece),
        .btn_held  (btn_held)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    // Advance past one rising edge; outputs are stable for sampling afterwards.
    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic quiet(input int n);
        btn_right = 1'b0;
        btn_left  = 1'b0;
        btn_drop  = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        logic [2:0] s;
        rst = 1'b1;
        tick();
        tick();
        for (int n = 0; n < 4; n++) begin
            s = {move_right, move_left, drop_piece};
            tests_run++;
            if (s !== 3'b000 || btn_held !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: strobes=%b held=%b, want 000/000", n, s, btn_held);
            end
            if (n == 1) rst = 1'b0;
            tick();
        end
    endtask

    // Right held edges 0..9: strobe after edge 7, held over edges 6..15.
    task automatic test_right_hold();
        logic [2:0] s, es, eh;
        btn_right = 1'b1;
        for (int n = 0; n <= 25; n++) begin
            tick();
            btn_right = (n + 1) < 10;
            s  = {move_right, move_left, drop_piece};
            es = (n == 7) ? 3'b100 : 3'b000;
            eh = (n >= 6 && n < 16) ? 3'b001 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL right_hold edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(10);
    endtask

    // Left bounces 2-on/2-off for 12 edges, then held from edge 12.
    task automatic test_left_bounce();
        logic [2:0] s, es, eh;
        btn_left = 1'b1;
        for (int n = 0; n <= 30; n++) begin
            tick();
            btn_left = ((n + 1) >= 12) ? 1'b1 : ((((n + 1) / 2) % 2) == 0);
            s  = {move_right, move_left, drop_piece};
            es = (n == 19) ? 3'b010 : 3'b000;
            eh = (n >= 18) ? 3'b010 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL left_bounce edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(15);
    endtask

    // Left held edges 0..49: strobes after 7,27,35,43,51.
    task automatic test_left_repeat();
        logic [2:0] s, es, eh;
        btn_left = 1'b1;
        for (int n = 0; n <= 70; n++) begin
            tick();
            btn_left = (n + 1) < 50;
            s  = {move_right, move_left, drop_piece};
            es = (n == 7 || n == 27 || n == 35 || n == 43 || n == 51) ? 3'b010 : 3'b000;
            eh = (n >= 6 && n < 56) ? 3'b010 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL left_repeat edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(10);
    endtask

    task automatic test_drop();
        logic [2:0] s, es, eh;
        // Drop held 100 cycles: single strobe, never repeated.
        btn_drop = 1'b1;
        for (int n = 0; n <= 110; n++) begin
            tick();
            btn_drop = (n + 1) < 100;
            s  = {move_right, move_left, drop_piece};
            es = (n == 7) ? 3'b001 : 3'b000;
            eh = (n >= 6 && n < 106) ? 3'b100 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL drop_hold edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(10);
        // Drop and right rise together: drop wins, that right strobe is lost.
        btn_drop  = 1'b1;
        btn_right = 1'b1;
        for (int n = 0; n <= 30; n++) begin
            tick();
            btn_drop  = (n + 1) < 15;
            btn_right = (n + 1) < 15;
            s  = {move_right, move_left, drop_piece};
            es = (n == 7) ? 3'b001 : 3'b000;
            eh = (n >= 6 && n < 21) ? 3'b101 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL drop_vs_right edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(10);
    endtask

    // Left held 0..69, right held 30..49: moves masked 37..56, left resumes on its grid.
    task automatic test_both_moves();
        logic [2:0] s, es, eh;
        btn_left  = 1'b1;
        btn_right = 1'b0;
        for (int n = 0; n <= 90; n++) begin
            tick();
            btn_left  = (n + 1) < 70;
            btn_right = ((n + 1) >= 30) && ((n + 1) < 50);
            s  = {move_right, move_left, drop_piece};
            es = (n == 7 || n == 27 || n == 35 || n == 59 || n == 67 || n == 75) ? 3'b010 : 3'b000;
            eh = 3'b000;
            if (n >= 6 && n < 76) eh[1] = 1'b1;
            if (n >= 36 && n < 56) eh[0] = 1'b1;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL both_moves edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        quiet(10);
    endtask

    // Reset sampled at edge 31 with left held: fresh press seen from edge 32.
    task automatic test_reset_mid();
        logic [2:0] s, es, eh;
        btn_left = 1'b1;
        for (int n = 0; n <= 85; n++) begin
            tick();
            rst      = (n == 30);
            btn_left = (n + 1) < 63;
            s  = {move_right, move_left, drop_piece};
            es = (n == 7 || n == 27 || n == 39 || n == 59 || n == 67) ? 3'b010 : 3'b000;
            eh = ((n >= 6 && n < 31) || (n >= 38 && n < 69)) ? 3'b010 : 3'b000;
            tests_run++;
            if (s !== es || btn_held !== eh) begin
                tests_failed++;
                $display("FAIL reset_mid edge %0d: strobes=%b held=%b, want %b/%b", n, s, btn_held, es, eh);
            end
        end
        rst = 1'b0;
        quiet(10);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        btn_right    = 1'b0;
        btn_left     = 1'b0;
        btn_drop     = 1'b0;
        test_reset();
        test_right_hold();
        test_left_bounce();
        test_left_repeat();
        test_drop();
        test_both_moves();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
